// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous code memory and queues {inst, pc} for decode.
// Optional perf counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes
`endif
);

    logic [31:0] fetch_pc;
    logic        pend;
    logic [31:0] pend_pc;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] buf_inst [BUF_DEPTH];
    logic [31:0] buf_pc   [BUF_DEPTH];

    logic        pop;
    logic        issue;
    logic [2:0]  credit;
    logic        unused_br_lsbs;

    assign unused_br_lsbs = ^br_target[1:0];

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    // Slots already committed (buffered + in flight) after this cycle's pop.
    assign credit    = {1'b0, count} + {2'b00, pend} - {2'b00, pop};
    assign issue     = (credit < 3'd2) & ~br_valid;

    assign mem_addr  = fetch_pc;
    assign out_inst  = buf_inst[rd_ptr];
    assign out_pc    = buf_pc[rd_ptr];

    // Request issue / response capture / head pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            pend     <= 1'b0;
            pend_pc  <= 32'h0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_inst[i] <= 32'h0;
                buf_pc[i]   <= 32'h0;
            end
        end else if (br_valid) begin
            fetch_pc <= {br_target[31:2], 2'b00};
            pend     <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pend) begin
                buf_inst[wr_ptr] <= mem_inst;
                buf_pc[wr_ptr]   <= pend_pc;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, pend} - {1'b0, pop};
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters; a pop in a redirect cycle still counts as fetched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= 32'h0;
            perf_stalls  <= 32'h0;
            perf_flushes <= 32'h0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
            if (br_valid) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule
